// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm: debounces one push-button and classifies press, release and long-press.
module button_debounce_fsm #(
  parameter int DEBOUNCE_MS = 50,
  parameter int LONG_LAPS   = 19
) (
  input  logic        clk_1KHz,
  input  logic        rst_n,
  input  logic        btn_raw,
  input  logic [31:0] count,
  output logic        count_trigger,
  output logic        btn_level,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        long_press,
  output logic        long_press_pulse
);
  typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, REL_ARM, REL_WAIT} state_t;
  localparam logic [31:0] HIT_VAL  = 32'(DEBOUNCE_MS);
  localparam logic [7:0]  LAST_LAP = 8'(LONG_LAPS - 1);
  state_t     state, state_n;
  logic       sync1, btn_s;
  logic [7:0] lap_cnt, lap_cnt_n;
  logic       trig_n, lvl_n, long_n, pp_n, rp_n, lpp_n;
  logic       lap_hit;
  assign lap_hit = count == HIT_VAL;
  always_comb begin
    state_n   = state;
    lap_cnt_n = lap_cnt;
    trig_n    = count_trigger;
    lvl_n     = btn_level;
    long_n    = long_press;
    pp_n      = 1'b0;
    rp_n      = 1'b0;
    lpp_n     = 1'b0;
    case (state)
      IDLE: if (btn_s) begin
        state_n = PRESS_WAIT;
        trig_n  = 1'b1;
      end
      PRESS_WAIT: if (!btn_s) begin
        state_n = IDLE;
        trig_n  = 1'b0;
      end else if (lap_hit) begin
        state_n   = PRESSED;
        lvl_n     = 1'b1;
        pp_n      = 1'b1;
        lap_cnt_n = 8'd0;
      end
      PRESSED: if (!btn_s) begin
        state_n = REL_ARM;
        trig_n  = 1'b0;
      end else if (lap_hit) begin
        if (lap_cnt == LAST_LAP && !long_press) begin
          long_n = 1'b1;
          lpp_n  = 1'b1;
        end else begin
          lap_cnt_n = (lap_cnt == 8'hFF) ? lap_cnt : lap_cnt + 8'd1;
        end
      end
      // one idle cycle lets the counter clear on the falling edge in between
      REL_ARM: begin
        state_n = REL_WAIT;
        trig_n  = 1'b1;
      end
      REL_WAIT: if (btn_s) begin
        state_n = PRESSED;
      end else if (lap_hit) begin
        state_n   = IDLE;
        trig_n    = 1'b0;
        lvl_n     = 1'b0;
        rp_n      = 1'b1;
        long_n    = 1'b0;
        lap_cnt_n = 8'd0;
      end
      default: begin
        state_n = IDLE;
        trig_n  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_1KHz) begin
    if (!rst_n) begin
      state            <= IDLE;
      sync1            <= 1'b0;
      btn_s            <= 1'b0;
      lap_cnt          <= 8'd0;
      count_trigger    <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press       <= 1'b0;
      long_press_pulse <= 1'b0;
    end else begin
      state            <= state_n;
      sync1            <= btn_raw;
      btn_s            <= sync1;
      lap_cnt          <= lap_cnt_n;
      count_trigger    <= trig_n;
      btn_level        <= lvl_n;
      press_pulse      <= pp_n;
      release_pulse    <= rp_n;
      long_press       <= long_n;
      long_press_pulse <= lpp_n;
    end
  end
endmodule

// File: tb/tb_button_debounce_fsm.sv
// tb_button_debounce_fsm: smart-counter stand-in, run-length reference model, directed and random stimulus.
module tb_button_debounce_fsm;
  localparam int D = 50;
  localparam int L = 19;
  logic        clk_1KHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_raw = 1'b0;
  logic [31:0] count = 32'd0;
  logic        trig, lvl, pp, rp, lp, lpp;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  button_debounce_fsm #(.DEBOUNCE_MS(D), .LONG_LAPS(L)) dut (
    .clk_1KHz(clk_1KHz), .rst_n(rst_n), .btn_raw(btn_raw), .count(count),
    .count_trigger(trig), .btn_level(lvl), .press_pulse(pp), .release_pulse(rp),
    .long_press(lp), .long_press_pulse(lpp)
  );
  always #5 clk_1KHz = ~clk_1KHz;
  always @(negedge clk_1KHz) count <= trig ? ((count == D) ? 32'd1 : count + 32'd1) : 32'd0;
  // model: run1 = consecutive high samples seen by the controller, rt = cycles since release began (+1)
  bit m_s1, m_bs, b, hit;
  int run1, rt, laps;
  bit e_lvl, e_long, e_trig, e_pp, e_rp, e_lpp;
  always @(posedge clk_1KHz) begin
    cyc++;
    e_pp  = 0;
    e_rp  = 0;
    e_lpp = 0;
    if (!rst_n) begin
      {m_s1, m_bs, e_lvl, e_long, e_trig} = '0;
      run1 = 0;
      rt   = 0;
      laps = 0;
    end else begin
      hit  = count == D;
      b    = m_bs;
      m_bs = m_s1;
      m_s1 = btn_raw;
      run1 = b ? run1 + 1 : 0;
      if (!e_lvl) begin
        if (run1 == D + 1) begin
          e_lvl = 1;
          e_pp  = 1;
          laps  = 0;
        end
      end else if (rt == 0) begin
        if (!b) rt = 1;
        else if (hit) begin
          if (laps == L - 1 && !e_long) begin
            e_long = 1;
            e_lpp  = 1;
          end else if (laps < 255) laps++;
        end
      end else begin
        rt++;
        if (rt >= 3 && b) rt = 0;
        else if (rt == D + 2) begin
          e_lvl  = 0;
          e_rp   = 1;
          e_long = 0;
          laps   = 0;
          rt     = 0;
        end
      end
      e_trig = e_lvl ? (rt != 1) : (run1 != 0);
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", n, cyc, a, e);
    end
  endtask
  always @(posedge clk_1KHz) begin
    #1;
    chk("m_trig", 32'(trig), 32'(e_trig));
    chk("m_lvl", 32'(lvl), 32'(e_lvl));
    chk("m_press", 32'(pp), 32'(e_pp));
    chk("m_rel", 32'(rp), 32'(e_rp));
    chk("m_long", 32'(lp), 32'(e_long));
    chk("m_lpulse", 32'(lpp), 32'(e_lpp));
  end
  task automatic at(input int n);
    if (cyc > n) begin
      checks++;
      errors++;
      $display("FAIL sched cyc %0d target %0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clk_1KHz);
      #1;
    end
  endtask
  task automatic raw_at(input int e, input bit v);
    at(e - 1);
    @(negedge clk_1KHz);
    btn_raw = v;
  endtask
  int k;
  initial begin
    at(3);
    chk("rst_lvl", 32'(lvl), 0);
    chk("rst_trig", 32'(trig), 0);
    @(negedge clk_1KHz);
    rst_n = 1'b1;
    // clean press and release
    k = cyc + 10;
    raw_at(k, 1);
    at(k + 51); chk("cp_pp_early", 32'(pp), 0); chk("cp_lvl_early", 32'(lvl), 0);
    at(k + 52); chk("cp_pp", 32'(pp), 1); chk("cp_lvl", 32'(lvl), 1);
    at(k + 53); chk("cp_pp_once", 32'(pp), 0); chk("cp_lvl_hold", 32'(lvl), 1);
    raw_at(k + 200, 0);
    at(k + 252); chk("cr_rel_early", 32'(rp), 0); chk("cr_lvl_hold", 32'(lvl), 1);
    at(k + 253); chk("cr_rel", 32'(rp), 1); chk("cr_lvl", 32'(lvl), 0); chk("cr_trig", 32'(trig), 0);
    at(k + 254); chk("cr_rel_once", 32'(rp), 0);
    // press bounce
    k = cyc + 10;
    for (int i = 0; i < 10; i++) raw_at(k + 3 * i, (i % 2) == 0);
    raw_at(k + 30, 0);
    at(k + 30); chk("pb_trig", 32'(trig), 0); chk("pb_count", count, 0); chk("pb_lvl", 32'(lvl), 0);
    // long press
    k = cyc + 60;
    raw_at(k, 1);
    at(k + 1001); chk("lp_early", 32'(lp), 0); chk("lpp_early", 32'(lpp), 0);
    at(k + 1002); chk("lp", 32'(lp), 1); chk("lpp", 32'(lpp), 1);
    at(k + 1003); chk("lpp_once", 32'(lpp), 0); chk("lp_hold", 32'(lp), 1);
    raw_at(k + 1100, 0);
    at(k + 1152); chk("lp_before_rel", 32'(lp), 1);
    at(k + 1153); chk("lp_rel", 32'(rp), 1); chk("lp_cleared", 32'(lp), 0);
    // release bounce: counter restarts after the abort, so long-press shifts to k+1013
    k = cyc + 10;
    raw_at(k, 1);
    raw_at(k + 310, 0);
    raw_at(k + 330, 1);
    at(k + 400); chk("rb_lvl", 32'(lvl), 1);
    at(k + 1012); chk("rb_lp_early", 32'(lp), 0);
    at(k + 1013); chk("rb_lp", 32'(lp), 1); chk("rb_lpp", 32'(lpp), 1);
    raw_at(k + 1100, 0);
    at(k + 1153); chk("rb_rel", 32'(rp), 1);
    // release seen on the same edge as a lap hit
    k = cyc + 10;
    raw_at(k, 1);
    raw_at(k + 100, 0);
    at(k + 152); chk("sim_rel_early", 32'(rp), 0);
    at(k + 153); chk("sim_rel", 32'(rp), 1); chk("sim_lvl", 32'(lvl), 0);
    // same collision, then re-press: the lost lap delays long-press to k+1053
    k = cyc + 10;
    raw_at(k, 1);
    raw_at(k + 100, 0);
    raw_at(k + 110, 1);
    at(k + 153); chk("sim2_lvl", 32'(lvl), 1);
    at(k + 1052); chk("sim2_lp_early", 32'(lp), 0);
    at(k + 1053); chk("sim2_lp", 32'(lp), 1);
    raw_at(k + 1100, 0);
    at(k + 1153); chk("sim2_rel", 32'(rp), 1);
    // reset mid-press
    k = cyc + 10;
    raw_at(k, 1);
    at(k + 499);
    @(negedge clk_1KHz);
    rst_n = 1'b0;
    at(k + 500);
    chk("rs_lvl", 32'(lvl), 0); chk("rs_trig", 32'(trig), 0); chk("rs_rel", 32'(rp), 0);
    @(negedge clk_1KHz);
    rst_n = 1'b1;
    at(k + 501); chk("rs_count", count, 0);
    at(k + 552); chk("rs_pp_early", 32'(pp), 0);
    at(k + 553); chk("rs_pp", 32'(pp), 1); chk("rs_lvl2", 32'(lvl), 1);
    raw_at(k + 600, 0);
    at(k + 700);
    // random bursts with occasional reset
    for (int s = 0; s < 160; s++) begin
      @(negedge clk_1KHz);
      btn_raw = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 40) != 0);
      @(negedge clk_1KHz);
      rst_n = 1'b1;
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(40, 400) : $urandom_range(1, 60)) @(negedge clk_1KHz);
    end
    btn_raw = 1'b0;
    repeat (120) @(negedge clk_1KHz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
